// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer producing per-stage enables for the 3PA pipeline.
// Define PCTRL_MULDIV_EN to enable the multi-cycle EX timer (MD_BUSY state, md_cnt).
module pipe_ctrl #(
  parameter int unsigned MD_CYCLES = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_use_stall,
  input  logic             br_taken,
  input  logic             dmem_busy,
  input  logic             imem_busy,
  input  logic             md_start,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exma_en,
  output logic             exma_bubble,
  output logic             mawb_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StMdBusy = 2'd2
  } state_e;

  // Control vector order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
  // exma_en, exma_bubble, mawb_en.
  localparam logic [7:0] CtlNone  = 8'h00;
  localparam logic [7:0] CtlRun   = 8'hD5;
  localparam logic [7:0] CtlStall = 8'h07;
  localparam logic [7:0] CtlRedir = 8'hFD;
  localparam logic [7:0] CtlWait  = 8'h75;

  state_e     state_q, state_d;
  logic [7:0] ctl;
  logic       redir_inc;
  logic       md_req;
  logic       md_hold;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] redir_cnt_q;

`ifdef PCTRL_MULDIV_EN
  logic [7:0] md_cnt_q, md_cnt_d;

  assign md_req  = md_start && (state_q == StRun);
  assign md_hold = (state_q == StMdBusy) && (md_cnt_q != 8'd0);
`else
  logic       unused_md_start;
  logic [7:0] unused_md_cycles;

  assign unused_md_start  = md_start;
  assign unused_md_cycles = 8'(MD_CYCLES);
  assign md_req           = 1'b0;
  assign md_hold          = 1'b0;
`endif

  always_comb begin
    ctl       = CtlNone;
    state_d   = state_q;
    redir_inc = 1'b0;
`ifdef PCTRL_MULDIV_EN
    md_cnt_d  = md_cnt_q;
`endif
    // Reset and data-memory freeze both leave everything at zero and hold state.
    if (!rst && !dmem_busy) begin
      if (state_q == StDrain) begin
        ctl = CtlWait;
        if (!imem_busy) state_d = StRun;
      end else if (md_hold) begin
        ctl = CtlStall;
`ifdef PCTRL_MULDIV_EN
        md_cnt_d = md_cnt_q - 8'd1;
`endif
      end else begin
        // RUN rules; also the MD release cycle, where md_req is already false.
        state_d = StRun;
        if (md_req) begin
          ctl     = CtlStall;
          state_d = StMdBusy;
`ifdef PCTRL_MULDIV_EN
          md_cnt_d = 8'(MD_CYCLES - 2);
`endif
        end else if (ld_use_stall) begin
          ctl = CtlStall;
        end else if (br_taken) begin
          ctl       = CtlRedir;
          redir_inc = 1'b1;
          if (imem_busy) state_d = StDrain;
        end else if (imem_busy) begin
          ctl = CtlWait;
        end else begin
          ctl = CtlRun;
        end
      end
    end
  end

  assign {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exma_en, exma_bubble, mawb_en} = ctl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
`ifdef PCTRL_MULDIV_EN
      md_cnt_q    <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef PCTRL_MULDIV_EN
      md_cnt_q <= md_cnt_d;
`endif
      if (!pc_en && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redir_inc && (redir_cnt_q != '1)) redir_cnt_q <= redir_cnt_q + CNT_W'(1);
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign redir_cnt = redir_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; a second CNT_W=4 instance covers saturation.
module tb_pipe_ctrl;

  localparam logic [7:0] CtlNone  = 8'h00;
  localparam logic [7:0] CtlRun   = 8'hD5;
  localparam logic [7:0] CtlStall = 8'h07;
  localparam logic [7:0] CtlRedir = 8'hFD;
  localparam logic [7:0] CtlWait  = 8'h75;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_use_stall = 1'b1, br_taken = 1'b1, dmem_busy = 1'b1, imem_busy = 1'b1;
  logic md_start = 1'b1;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exma_en, exma_bubble, mawb_en;
  logic [1:0]  state;
  logic [15:0] stall_cnt, redir_cnt;

  logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush;
  logic        s_exma_en, s_exma_bubble, s_mawb_en;
  logic [1:0]  s_state;
  logic [3:0]  s_stall_cnt, s_redir_cnt;

  logic [7:0]  ctl;
  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exma_en, exma_bubble, mawb_en};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MD_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ld_use_stall(ld_use_stall), .br_taken(br_taken),
    .dmem_busy(dmem_busy), .imem_busy(imem_busy), .md_start(md_start),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exma_en(exma_en), .exma_bubble(exma_bubble), .mawb_en(mawb_en),
    .state(state), .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
  );

  pipe_ctrl #(.MD_CYCLES(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .ld_use_stall(ld_use_stall), .br_taken(br_taken),
    .dmem_busy(dmem_busy), .imem_busy(imem_busy), .md_start(md_start),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
    .idex_flush(s_idex_flush), .exma_en(s_exma_en), .exma_bubble(s_exma_bubble),
    .mawb_en(s_mawb_en), .state(s_state), .stall_cnt(s_stall_cnt), .redir_cnt(s_redir_cnt)
  );

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic r, input logic ld, input logic br, input logic dm,
                     input logic im, input logic md);
    @(posedge clk);
    #1;
    rst = r; ld_use_stall = ld; br_taken = br; dmem_busy = dm; imem_busy = im; md_start = md;
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 1, 1, 1);
      checks++;
      if (ctl !== CtlNone) begin
        errors++; $display("FAIL reset_ctl[%0d]: got %h expected %h", i, ctl, CtlNone);
      end
    end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++;
    if (ctl !== CtlRun) begin errors++; $display("FAIL reset_run: got %h expected %h", ctl, CtlRun); end
    checks++;
    if (stall_cnt !== 16'd0 || redir_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, redir_cnt);
    end
  endtask

  task automatic test_load_use;
    cyc(0, 1, 0, 0, 0, 0);
    checks++;
    if (ctl !== CtlStall) begin errors++; $display("FAIL lu_stall: got %h expected %h", ctl, CtlStall); end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (ctl !== CtlRun) begin errors++; $display("FAIL lu_after: got %h expected %h", ctl, CtlRun); end
    checks++;
    if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_branch_drain;
    cyc(0, 0, 1, 0, 1, 0);                       // N
    checks++;
    if (ctl !== CtlRedir) begin errors++; $display("FAIL br_n: got %h expected %h", ctl, CtlRedir); end
    cyc(0, 0, 0, 0, 1, 0);                       // N+1
    checks++;
    if (state !== 2'd1 || ctl !== CtlWait) begin
      errors++; $display("FAIL br_drain1: got state %0d ctl %h expected 1 %h", state, ctl, CtlWait);
    end
    checks++;
    if (redir_cnt !== 16'd1) begin errors++; $display("FAIL br_redir: got %0d expected 1", redir_cnt); end
    cyc(0, 1, 1, 0, 1, 1);                       // N+2: requests ignored in DRAIN
    checks++;
    if (state !== 2'd1 || ctl !== CtlWait) begin
      errors++; $display("FAIL br_drain2: got state %0d ctl %h expected 1 %h", state, ctl, CtlWait);
    end
    cyc(0, 0, 0, 0, 0, 0);                       // N+3: wrong-path fetch returns
    checks++;
    if (state !== 2'd1 || ctl !== CtlWait) begin
      errors++; $display("FAIL br_drain3: got state %0d ctl %h expected 1 %h", state, ctl, CtlWait);
    end
    cyc(0, 0, 0, 0, 0, 0);                       // N+4
    checks++;
    if (state !== 2'd0 || ctl !== CtlRun) begin
      errors++; $display("FAIL br_run: got state %0d ctl %h expected 0 %h", state, ctl, CtlRun);
    end
    checks++;
    if (redir_cnt !== 16'd1) begin errors++; $display("FAIL br_ignored: got %0d expected 1", redir_cnt); end
    cyc(0, 0, 1, 0, 0, 0);                       // branch with no fetch outstanding
    checks++;
    if (ctl !== CtlRedir) begin errors++; $display("FAIL br_quick: got %h expected %h", ctl, CtlRedir); end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (state !== 2'd0 || redir_cnt !== 16'd2) begin
      errors++; $display("FAIL br_quick_next: got state %0d redir %0d expected 0 2", state, redir_cnt);
    end
  endtask

  task automatic test_muldiv;
`ifdef PCTRL_MULDIV_EN
    logic [7:0] exp_ctl [6] = '{CtlStall, CtlNone, CtlStall, CtlStall, CtlRun, CtlRun};
    logic [1:0] exp_st  [6] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, (i == 1), 0, (i == 0));
      checks++;
      if (ctl !== exp_ctl[i] || state !== exp_st[i]) begin
        errors++;
        $display("FAIL md[N+%0d]: got ctl %h state %0d expected %h %0d",
                 i, ctl, state, exp_ctl[i], exp_st[i]);
      end
    end
`else
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (ctl !== CtlRun) begin errors++; $display("FAIL md_ignored: got %h expected %h", ctl, CtlRun); end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL md_state: got %0d expected 0", state); end
`endif
  endtask

  task automatic test_priority;
    logic [15:0] redir_before;
    redir_before = redir_cnt;
    cyc(0, 1, 1, 1, 0, 1);
    checks++;
    if (ctl !== CtlNone) begin errors++; $display("FAIL prio_freeze: got %h expected %h", ctl, CtlNone); end
    cyc(0, 1, 1, 0, 0, 1);
    checks++;
    if (state !== 2'd0 || ctl !== CtlStall) begin
      errors++; $display("FAIL prio_drop: got state %0d ctl %h expected 0 %h", state, ctl, CtlStall);
    end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
`ifdef PCTRL_MULDIV_EN
    if (state !== 2'd2) begin errors++; $display("FAIL prio_md: got %0d expected 2", state); end
`else
    if (state !== 2'd0) begin errors++; $display("FAIL prio_md: got %0d expected 0", state); end
`endif
    checks++;
    if (redir_cnt !== redir_before) begin
      errors++; $display("FAIL prio_redir: got %0d expected %0d", redir_cnt, redir_before);
    end
  endtask

  task automatic test_reset_abort;
    cyc(0, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);                       // reset while in DRAIN
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (state !== 2'd0 || ctl !== CtlRun) begin
      errors++; $display("FAIL abort: got state %0d ctl %h expected 0 %h", state, ctl, CtlRun);
    end
  endtask

  task automatic test_saturation;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      if (i == 0) begin
        checks++;
        if (s_ctl_ok() == 1'b0) begin
          errors++; $display("FAIL sat_wait: got pc_en %b ifid_flush %b expected 0 1",
                             s_pc_en, s_ifid_flush);
        end
      end
    end
    cyc(0, 0, 0, 0, 1, 0);
    checks++;
    if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d expected 15", s_stall_cnt); end
    checks++;
    if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide: got %0d expected 20", stall_cnt); end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", s_stall_cnt); end
  endtask

  function automatic logic s_ctl_ok();
    return (s_pc_en === 1'b0) && (s_ifid_flush === 1'b1) && (s_ifid_en === 1'b1);
  endfunction

  initial begin
    test_reset();
    test_load_use();
    test_branch_drain();
    test_muldiv();
    test_priority();
    test_reset_abort();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush sequencer for the 3PA core. Combines hazard and wait requests into one set of per-stage register enables, flushes and bubble inserts, so each pipeline register has a single owner of its enable/clear. Inputs come from the forwarding/hazard unit, the EX branch resolver and the instruction/data memory ports. An optional multi-cycle EX operation timer is included, along with saturating stall and redirect performance counters.

## Interface
- MD_CYCLES, 4: EX occupancy in cycles of a multi-cycle op; legal range 2..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_use_stall  in  1  load-use hazard from the hazard unit; load is in MA and its consumer is in EX.
- br_taken  in  1  branch/jump in EX resolved taken; PC target is valid this cycle.
- dmem_busy  in  1  data memory not ready; the whole pipe must hold.
- imem_busy  in  1  instruction fetch not complete this cycle.
- md_start  in  1  EX holds a multi-cycle op. Ignored unless PCTRL_MULDIV_EN is defined.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_en  out  1  ID/EX register enable.
- idex_flush  out  1  ID/EX loads a NOP.
- exma_en  out  1  EX/MA register enable.
- exma_bubble  out  1  EX/MA loads a NOP instead of the EX result.
- mawb_en  out  1  MA/WB register enable.
- state  out  2  RUN=0, DRAIN=1, MD_BUSY=2.
- stall_cnt  out  CNT_W  count of cycles with pc_en=0; saturating.
- redir_cnt  out  CNT_W  count of accepted taken branches; saturating.

## Operation
- Outputs are a combinational function of the registered state and the current inputs.
- **Freeze** (dmem_busy=1, any state): all enables 0, all flush/bubble 0, state and md counter hold.
- Definitions used below:
  - **Run profile**: all enables 1, all flush/bubble 0.
  - **Stall profile**: pc_en=ifid_en=idex_en=0, exma_en=1, exma_bubble=1, mawb_en=1.
- **RUN** (dmem_busy=0). First matching condition wins:
  - md_start (macro on): stall profile; md_cnt<=MD_CYCLES-2; go to MD_BUSY.
  - ld_use_stall: stall profile for this cycle; stay in RUN.
  - br_taken: run profile plus ifid_flush=1 and idex_flush=1; redir_cnt+1. If imem_busy=1 in the same cycle, go to DRAIN; otherwise stay in RUN.
  - imem_busy: pc_en=0, ifid_flush=1, all other enables 1.
  - otherwise: run profile.
- **DRAIN**: discards the wrong-path fetch that was outstanding at the redirect. The PC already holds the target.
  - Outputs: pc_en=0, ifid_flush=1, ifid_en=idex_en=exma_en=mawb_en=1.
  - ld_use_stall, br_taken and md_start are ignored; only bubbles occupy ID/EX.
  - When imem_busy=0, the returned wrong-path instruction is flushed this cycle and state goes to RUN.
- **MD_BUSY** (macro on):
  - md_cnt≠0: stall profile; md_cnt-1.
  - md_cnt=0: release cycle. Outputs and next state follow the RUN rules with md_start ignored; the op leaves EX this cycle.
- Counters:
  - stall_cnt increments when pc_en=0 (including freeze) and rst=0.
  - Both counters saturate at all-ones.
  - CNT_W-bit unsigned; no wrap.

## Timing
- Reset values (while rst=1 and after release):
  - state=RUN, md_cnt=0, stall_cnt=0, redir_cnt=0.
  - While rst=1: all enables 0, all flush/bubble 0, no counting.
- Reset mid-DRAIN or mid-MD_BUSY aborts the sequence; the next cycle after release is RUN.
- Zero-latency control: each request affects enables in the same cycle it is asserted.
- ld_use_stall costs exactly one bubble per assertion cycle.
- Multi-cycle op:
  - EX occupancy is exactly MD_CYCLES cycles, i.e. MD_CYCLES-1 stall cycles.
  - dmem_busy cycles inside MD_BUSY add to the occupancy without decrementing md_cnt.
- Redirect penalty:
  - Two flushed slots when no fetch is outstanding.
  - With a fetch outstanding: two slots plus one per DRAIN cycle.
- Inputs must not depend combinationally on any output.

## Configuration
- PCTRL_MULDIV_EN defined:
  - MD_BUSY state and md_cnt (8 bits) are present.
  - md_start is honoured as described under Operation.
- PCTRL_MULDIV_EN undefined:
  - md_start is ignored and md_cnt is not synthesised.
  - state never equals 2.
  - All other behaviour is identical.

## Test plan
- Reset: hold rst 3 cycles with all inputs 1, then release with all inputs 0. Required: enables 0 during reset; next cycle state=0, all enables 1, both counters 0.
- Load-use: ld_use_stall=1 for one cycle. Required: pc_en=ifid_en=idex_en=0 and exma_bubble=1 that cycle only; stall_cnt=1.
- Branch with fetch outstanding: br_taken=1 and imem_busy=1 at cycle N, imem_busy held through N+2.
  - Cycle N: ifid_flush=idex_flush=1, redir_cnt=1, state=DRAIN from N+1.
  - Cycle N+3: ifid_flush=1 with imem_busy=0.
  - Cycle N+4: RUN.
- Multi-cycle op (macro on, MD_CYCLES=4): md_start=1 at cycle N, dmem_busy=1 at N+1.
  - Stall profile at N, N+2, N+3; freeze at N+1.
  - Release at N+4; state=0 at N+5.
- Priority: dmem_busy, md_start, ld_use_stall and br_taken all 1 in RUN → freeze, state holds. Then drop dmem_busy → MD_BUSY entered, redir_cnt unchanged.
- Saturation: CNT_W=4, imem_busy=1 for 20 cycles → stall_cnt=15, stays 15.
